// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences each instruction and
// drives every datapath select/enable plus the 3-bit ALU operation code.
module multicycle_controller #(
   parameter int S_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [5:0]     op,
   input  logic [5:0]     funct,
   input  logic           zero,
   output logic           iord,
   output logic           memwrite,
   output logic           irwrite,
   output logic           regdst,
   output logic           memtoreg,
   output logic           regwrite,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [2:0]     alucontrol,
   output logic [1:0]     pcsrc,
   output logic           pcen,
   output logic [S_W-1:0] state
);

   localparam logic [S_W-1:0] FETCH    = S_W'(0);
   localparam logic [S_W-1:0] DECODE   = S_W'(1);
   localparam logic [S_W-1:0] MEMADR   = S_W'(2);
   localparam logic [S_W-1:0] MEMRD    = S_W'(3);
   localparam logic [S_W-1:0] MEMWB    = S_W'(4);
   localparam logic [S_W-1:0] MEMWR    = S_W'(5);
   localparam logic [S_W-1:0] EXECUTE  = S_W'(6);
   localparam logic [S_W-1:0] ALUWB    = S_W'(7);
   localparam logic [S_W-1:0] BRANCH   = S_W'(8);
   localparam logic [S_W-1:0] ADDIEXEC = S_W'(9);
   localparam logic [S_W-1:0] ADDIWB   = S_W'(10);
   localparam logic [S_W-1:0] JUMP     = S_W'(11);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [S_W-1:0] next_state;
   logic           pcwrite;
   logic           branch;

   // Unrecognised funct codes fall back to add so the instruction still retires.
   function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FETCH;
      else        state <= next_state;
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXECUTE;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDIEXEC;
               OP_J:         next_state = JUMP;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:   next_state = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:    next_state = MEMWB;
         EXECUTE:  next_state = ALUWB;
         ADDIEXEC: next_state = ADDIWB;
         default:  next_state = FETCH;
      endcase
   end

   always_comb begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b010;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      case (state)
         FETCH: begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            alusrcb = 2'b01;
         end
         DECODE:   alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:    iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         EXECUTE: begin
            alusrca    = 1'b1;
            alucontrol = funct_to_alu(funct);
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branch     = 1'b1;
         end
         ADDIEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB:   regwrite = 1'b1;
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      // Reset kills all writes immediately and parks the selects on their fetch values.
      if (!rst_n) begin
         iord       = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 1'b0;
         regdst     = 1'b0;
         memtoreg   = 1'b0;
         regwrite   = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = 2'b01;
         alucontrol = 3'b010;
         pcsrc      = 2'b00;
         pcwrite    = 1'b0;
         branch     = 1'b0;
      end
   end

   assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction state traces and
// output vectors are predicted from the instruction class and compared every cycle.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   multicycle_controller #(.S_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
      .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,alucontrol,pcsrc,pcen}
   localparam logic [14:0] RESET_VEC = {7'b0000000, 2'b01, 3'b010, 2'b00, 1'b0};

   int checks = 0;
   int errors = 0;
   int tr[$];

   wire [14:0] obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                      alusrcb, alucontrol, pcsrc, pcen};

   function automatic void build_trace(input logic [5:0] o);
      tr.delete();
      case (o)
         OP_LW:   tr = {0, 1, 2, 3, 4};
         OP_SW:   tr = {0, 1, 2, 5};
         OP_R:    tr = {0, 1, 6, 7};
         OP_ADDI: tr = {0, 1, 9, 10};
         OP_BEQ:  tr = {0, 1, 8};
         OP_J:    tr = {0, 1, 11};
         default: tr = {0, 1};
      endcase
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      if (f == 6'b100010) return 3'b110;
      if (f == 6'b100100) return 3'b000;
      if (f == 6'b100101) return 3'b001;
      if (f == 6'b101010) return 3'b111;
      return 3'b010;
   endfunction

   function automatic logic [14:0] exp_vec(input int st, input logic [5:0] f, input logic z);
      logic io, mw, ir, rd, m2r, rw, asa, pe;
      logic [1:0] asb, pcs;
      logic [2:0] alu;
      {io, mw, ir, rd, m2r, rw, asa, pe} = 8'b0;
      asb = 2'b00; alu = 3'b010; pcs = 2'b00;
      case (st)
         0:  begin ir = 1; asb = 2'b01; pe = 1; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  io = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin io = 1; mw = 1; end
         6:  begin asa = 1; alu = alu_of(f); end
         7:  begin rd = 1; rw = 1; end
         8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pe = z; end
         9:  begin asa = 1; asb = 2'b10; end
         10: rw = 1;
         11: begin pcs = 2'b10; pe = 1; end
         default: ;
      endcase
      return {io, mw, ir, rd, m2r, rw, asa, asb, alu, pcs, pe};
   endfunction

   // zmode: 0/1 fixes zero in BRANCH, 2 randomizes it everywhere; nsteps<0 runs the whole trace.
   task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int zmode,
                            input int nsteps);
      build_trace(iop);
      for (int i = 0; i < tr.size() && (nsteps < 0 || i < nsteps); i++) begin
         int st;
         logic zb;
         st = tr[i];
         if (st == 1 || st == 2 || st == 6) begin
            op = iop; funct = ifn;
         end else begin
            op = 6'($urandom); funct = 6'($urandom);
         end
         zb = (zmode == 2 || st != 8) ? 1'($urandom_range(0, 1)) : (zmode == 1);
         zero = zb;
         @(negedge clk);
         checks++;
         if (state !== 4'(st)) begin
            errors++;
            $display("FAIL state op=%b step=%0d: got %0d expected %0d", iop, i, state, st);
         end
         checks++;
         if (obs !== exp_vec(st, ifn, zb)) begin
            errors++;
            $display("FAIL outputs op=%b funct=%b st=%0d z=%b: got %b expected %b",
                     iop, ifn, st, zb, obs, exp_vec(st, ifn, zb));
         end
         checks++;
         if (((pcen & memwrite) | (regwrite & memwrite)) !== 1'b0) begin
            errors++;
            $display("FAIL exclusive st=%0d: pcen=%b regwrite=%b memwrite=%b expected no overlap",
                     st, pcen, regwrite, memwrite);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op = OP_LW; zero = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (state !== 4'd0) begin
         errors++; $display("FAIL reset_state: got %0d expected 0", state);
      end
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("FAIL reset_outputs: got %b expected %b", obs, RESET_VEC);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(0, 6'd0, 1'b0)) begin
         errors++; $display("FAIL release_fetch: got %b expected %b", obs, exp_vec(0, 6'd0, 1'b0));
      end
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
   endtask

   task automatic test_lw_sw();
      run_instr(OP_LW, 6'($urandom), 2, -1);
      run_instr(OP_SW, 6'($urandom), 2, -1);
   endtask

   task automatic test_rtype();
      logic [5:0] fl[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
      foreach (fl[k]) run_instr(OP_R, fl[k], 2, -1);
   endtask

   task automatic test_beq();
      run_instr(OP_BEQ, 6'd0, 1, -1);
      run_instr(OP_BEQ, 6'd0, 0, -1);
      run_instr(OP_ADDI, 6'd0, 2, -1);
   endtask

   task automatic test_misc();
      run_instr(OP_ADDI, 6'($urandom), 2, -1);
      run_instr(OP_J, 6'($urandom), 2, -1);
      run_instr(6'b111111, 6'($urandom), 2, -1);
   endtask

   task automatic test_midreset();
      run_instr(OP_LW, 6'd0, 2, 3);
      rst_n = 1'b0; op = OP_LW;
      @(negedge clk);
      checks++;
      if (state !== 4'd3 || obs !== RESET_VEC) begin
         errors++; $display("FAIL midreset_enter: got st=%0d %b expected st=3 %b", state, obs, RESET_VEC);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (state !== 4'd0 || obs !== RESET_VEC) begin
            errors++; $display("FAIL midreset_hold: got st=%0d %b expected st=0 %b", state, obs, RESET_VEC);
         end
      end
      @(posedge clk); #1; rst_n = 1'b1;
      run_instr(OP_LW, 6'd0, 2, -1);
   endtask

   task automatic test_random();
      logic [5:0] ops[7] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J, 6'b111111};
      for (int n = 0; n < 150; n++) begin
         logic [5:0] o;
         o = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 9) == 0) o = 6'($urandom);
         run_instr(o, 6'($urandom), 2, -1);
      end
   endtask

   initial begin
      test_reset();
      test_lw_sw();
      test_rtype();
      test_beq();
      test_misc();
      test_midreset();
      test_random();
      @(negedge clk);
      checks++;
      if (state !== 4'd0) begin
         errors++; $display("FAIL final_state: got %0d expected 0", state);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
